// File: rtl/bidir_io_pkg.sv
// Shared definitions for the half-duplex pin endpoint: state encoding,
// parameter limits and a counter-width helper.
package bidir_io_pkg;

    typedef enum logic [1:0] {
        StRx     = 2'd0,
        StTurnTx = 2'd1,
        StTx     = 2'd2,
        StTurnRx = 2'd3
    } state_e;

    localparam int unsigned MinSyncStages = 2;
    localparam int unsigned MinFiltLen    = 1;
    localparam int unsigned MinTurnCyc    = 1;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_sync_filter.sv
// Pin synchronizer and glitch filter. rise/fall are strobes that are high
// for the cycle in which rx_data is about to change.
module io_sync_filter
    import bidir_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rx_data,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] CntLast = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rx_q;
    logic                   s;
    logic                   update;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        update = (s != rx_q) && (cnt_q == CntLast);
        cnt_d  = cnt_q + 1'b1;
        if ((s == rx_q) || update) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            rx_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            cnt_q  <= cnt_d;
            if (update) begin
                rx_q <= s;
            end
        end
    end

    assign rx_data = rx_q;
    assign rise    = update & s;
    assign fall    = update & ~s;

endmodule

// File: rtl/bidir_io_turnaround.sv
// Half-duplex endpoint for one shared pin: filtered receive path plus an
// ownership FSM that keeps the pin undriven for a guard interval on each turn.
module bidir_io_turnaround
    import bidir_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3,
    parameter int unsigned TURN_CYC    = 2
) (
    input  logic clk,
    input  logic rst_n,
    inout  wire  io,
    input  logic tx_req,
    input  logic tx_data,
    output logic tx_ack,
    output logic drv_en,
    output logic rx_data,
    output logic rx_valid,
    output logic rx_rise,
    output logic rx_fall
);

    if (SYNC_STAGES < MinSyncStages) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < MinFiltLen) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end
    if (TURN_CYC < MinTurnCyc) begin : g_bad_turn
        $error("TURN_CYC must be at least 1");
    end

    localparam int unsigned GW = cnt_width(TURN_CYC);
    localparam logic [GW-1:0] GuardLast = GW'(TURN_CYC - 1);

    state_e        state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          tx_q, tx_d;
    logic          drive_q;
    logic          valid_q;
    logic          rise_q, fall_q;
    logic          rise_raw, fall_raw;

    io_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin     (io),
        .rx_data (rx_data),
        .rise    (rise_raw),
        .fall    (fall_raw)
    );

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        tx_d    = tx_q;
        unique case (state_q)
            StRx: begin
                if (tx_req) begin
                    state_d = StTurnTx;
                    guard_d = GuardLast;
                end
            end
            StTurnTx: begin
                if (!tx_req) begin
                    state_d = StRx;
                end else if (guard_q == '0) begin
                    state_d = StTx;
                    tx_d    = tx_data;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            StTx: begin
                if (tx_req) begin
                    tx_d = tx_data;
                end else begin
                    state_d = StTurnRx;
                    guard_d = GuardLast;
                end
            end
            StTurnRx: begin
                if (guard_q == '0) begin
                    state_d = StRx;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            default: state_d = StRx;
        endcase
    end

    // Outputs are registered from the next state so they track the state
    // register exactly; edge pulses are gated by the state before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRx;
            guard_q <= '0;
            tx_q    <= 1'b0;
            drive_q <= 1'b0;
            valid_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            tx_q    <= tx_d;
            drive_q <= (state_d == StTx);
            valid_q <= (state_d == StRx);
            rise_q  <= rise_raw && (state_q == StRx);
            fall_q  <= fall_raw && (state_q == StRx);
        end
    end

    assign io       = drive_q ? tx_q : 1'bz;
    assign drv_en   = drive_q;
    assign tx_ack   = drive_q;
    assign rx_valid = valid_q;
    assign rx_rise  = rise_q;
    assign rx_fall  = fall_q;

endmodule
